// File: rtl/waveform_pkg.sv
// waveform_pkg: shared frame constants and lock-state type for the half-cycle waveform protocol
package waveform_pkg;
  localparam int FRAME_LEN = 8;
  // Index [i] is signal i (0 = sig1), bit k is the expected level at sample k.
  localparam logic [2:0][7:0] EXP_POS = {8'b0001_0000, 8'b0001_0000, 8'b0011_1000};
  localparam logic [2:0][7:0] EXP_NEG = {8'b0000_1000, 8'b0000_1000, 8'b0001_1100};
  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
  // Gather the three signals' expected levels for one sample index.
  function automatic logic [2:0] exp_col(input logic [2:0][7:0] tbl, input logic [2:0] k);
    return {tbl[2][k], tbl[1][k], tbl[0][k]};
  endfunction
endpackage

// File: rtl/waveform_neg_sampler.sv
// waveform_neg_sampler: negedge slot counter with sample and index capture
module waveform_neg_sampler (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sig_in,
  output logic [2:0] neg_samp,
  output logic [2:0] neg_idx
);
  logic [2:0] neg_cnt;
  // Capture each negedge sample together with the slot it belongs to.
  always_ff @(negedge clk) begin
    if (rst) begin
      neg_cnt  <= '0;
      neg_samp <= '0;
      neg_idx  <= '0;
    end else begin
      neg_cnt  <= neg_cnt + 3'd1;
      neg_samp <= sig_in;
      neg_idx  <= neg_cnt;
    end
  end
endmodule

// File: rtl/waveform_checker.sv
// waveform_checker: compares both-edge samples against the expected frame and tracks lock
module waveform_checker
  import waveform_pkg::*;
#(
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sig_in,
  output logic       err_valid,
  output logic [2:0] err_slot,
  output logic [2:0] err_pos,
  output logic [2:0] err_neg,
  output logic       frame_done,
  output logic       frame_ok,
  output logic [7:0] err_count,
  output logic       locked
);
  localparam int CW = $clog2(LOCK_FRAMES + 1);
  localparam logic [2:0] LAST = 3'(FRAME_LEN - 1);
  logic [2:0] pos_cnt, neg_samp, neg_idx, mis_pos, mis_neg;
  logic first, frame_err, slot_err, last, frame_clean, clean_done;
  logic [CW-1:0] clean_cnt;
  lock_state_t state, state_nxt;
  waveform_neg_sampler u_neg (
    .clk(clk),
    .rst(rst),
    .sig_in(sig_in),
    .neg_samp(neg_samp),
    .neg_idx(neg_idx)
  );
  // Slot compare; the negedge sample is meaningless before the first negedge after reset.
  always_comb begin
    mis_pos     = sig_in ^ exp_col(EXP_POS, pos_cnt);
    mis_neg     = first ? 3'b000 : neg_samp ^ exp_col(EXP_NEG, neg_idx);
    slot_err    = |{mis_pos, mis_neg};
    last        = pos_cnt == LAST;
    frame_clean = !(frame_err || slot_err);
    clean_done  = frame_clean && clean_cnt >= CW'(LOCK_FRAMES - 1);
  end
  // Lock state register.
  always_ff @(posedge clk) state <= rst ? UNLOCKED : state_nxt;
  // Lock next state: drop on any slot error, acquire at the end of the qualifying clean frame.
  always_comb state_nxt = state == LOCKED ? (slot_err ? UNLOCKED : LOCKED) : (last && clean_done ? LOCKED : UNLOCKED);
  // Lock output.
  always_comb locked = state == LOCKED;
  // Registered report outputs, frame tracking, saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos_cnt    <= '0;
      first      <= 1'b1;
      frame_err  <= 1'b0;
      clean_cnt  <= '0;
      err_valid  <= 1'b0;
      err_slot   <= '0;
      err_pos    <= '0;
      err_neg    <= '0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      err_count  <= '0;
    end else begin
      pos_cnt    <= pos_cnt + 3'd1;
      first      <= 1'b0;
      frame_err  <= !last && (frame_err || slot_err);
      clean_cnt  <= (state == LOCKED && slot_err) || (last && !frame_clean) ? '0 :
                    last && clean_cnt != CW'(LOCK_FRAMES) ? clean_cnt + CW'(1) : clean_cnt;
      err_valid  <= slot_err;
      err_slot   <= pos_cnt;
      err_pos    <= mis_pos;
      err_neg    <= mis_neg;
      frame_done <= last;
      frame_ok   <= last && frame_clean;
      err_count  <= err_count + {7'd0, slot_err && err_count != 8'hFF};
    end
  end
endmodule
